ycbcr_block_sequencer: RTL and testbench

- Sequences one block of RGB pixels from a single-port pixel buffer through the fixed-latency, non-stallable YCbCr conversion datapath.
- Collects the Y/Cb/Cr results and presents them on a valid/ready stream to the downstream DCT/quantisation stage.
- Uses credit-based issue so results are never lost under downstream backpressure, even though the datapath has no enable.
- Sits between the frame/block buffer and the conversion datapath. One instance serves one datapath instance.

---
 rtl/ycbcr_block_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_ycbcr_block_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_block_sequencer.sv
// ycbcr_block_sequencer
//
// Streams one block of RGB pixels from a single-port pixel buffer through a
// fixed-latency, non-stallable YCbCr conversion datapath. The Y/Cb/Cr results
// are collected in a first-word-fall-through FIFO and presented on a
// valid/ready stream. Pixels are issued only against credit, so every result
// always has a FIFO slot waiting for it when it leaves the datapath.
//
// Ports:
//   clk, rst_n                 clock and synchronous reset (rst_n = 1 resets;
//                              the name is kept for port-name consistency)
//   start, busy, done          block request, activity flag, completion pulse
//   rd_en, rd_addr             pixel buffer read strobe and pixel index
//   rd_r, rd_g, rd_b           buffer read data, valid one cycle after rd_en
//   conv_r, conv_g, conv_b     registered datapath inputs (0 when idle)
//   conv_y, conv_cb, conv_cr   datapath outputs
//   out_valid, out_ready       result stream handshake
//   out_y, out_cb, out_cr      result words of the FIFO head
//   out_index, out_last        pixel index of the head, last-pixel marker
module ycbcr_block_sequencer #(
  parameter int unsigned INPUT_WIDTH        = 8,
  parameter int unsigned FIXED_POINT_LENGTH = 32,
  parameter int unsigned BLOCK_SIZE         = 64,
  parameter int unsigned ADDR_WIDTH         = 6,
  parameter int unsigned CONV_LATENCY       = 3,
  parameter int unsigned FIFO_DEPTH         = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic [INPUT_WIDTH-1:0]        rd_r,
  input  logic [INPUT_WIDTH-1:0]        rd_g,
  input  logic [INPUT_WIDTH-1:0]        rd_b,
  output logic [INPUT_WIDTH-1:0]        conv_r,
  output logic [INPUT_WIDTH-1:0]        conv_g,
  output logic [INPUT_WIDTH-1:0]        conv_b,
  input  logic [FIXED_POINT_LENGTH-1:0] conv_y,
  input  logic [FIXED_POINT_LENGTH-1:0] conv_cb,
  input  logic [FIXED_POINT_LENGTH-1:0] conv_cr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FIXED_POINT_LENGTH-1:0] out_y,
  output logic [FIXED_POINT_LENGTH-1:0] out_cb,
  output logic [FIXED_POINT_LENGTH-1:0] out_cr,
  output logic [ADDR_WIDTH-1:0]         out_index,
  output logic                          out_last
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned IssW = ADDR_WIDTH + 1;

  localparam logic [IssW-1:0]       BlockSz  = IssW'(BLOCK_SIZE);
  localparam logic [IssW-1:0]       LastIss  = IssW'(BLOCK_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(BLOCK_SIZE - 1);
  localparam logic [CntW-1:0]       DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [PtrW-1:0]       LastPtr  = PtrW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                                   state_q, state_d;
  logic [IssW-1:0]                          issue_cnt_q, issue_cnt_d;
  // Read stage: pixel issued last cycle, its buffer data is on rd_* now.
  logic                                     pend_vld_q, pend_vld_d;
  logic [ADDR_WIDTH-1:0]                    pend_idx_q, pend_idx_d;
  // Tag stages run alongside the datapath; stage 0 loads with conv_*.
  logic [CONV_LATENCY-1:0]                  tag_vld_q, tag_vld_d;
  logic [CONV_LATENCY-1:0][ADDR_WIDTH-1:0]  tag_idx_q, tag_idx_d;
  logic [INPUT_WIDTH-1:0]                   conv_r_q, conv_r_d;
  logic [INPUT_WIDTH-1:0]                   conv_g_q, conv_g_d;
  logic [INPUT_WIDTH-1:0]                   conv_b_q, conv_b_d;
  // Pixels issued but not yet pushed into the FIFO (read stage + tag stages).
  logic [CntW-1:0]                          inflight_q, inflight_d;
  logic [CntW-1:0]                          fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]                          wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]                          rd_ptr_q, rd_ptr_d;

  logic [FIXED_POINT_LENGTH-1:0] y_mem_q   [FIFO_DEPTH];
  logic [FIXED_POINT_LENGTH-1:0] cb_mem_q  [FIFO_DEPTH];
  logic [FIXED_POINT_LENGTH-1:0] cr_mem_q  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]         idx_mem_q [FIFO_DEPTH];

  logic credit_ok, issue, push, pop, head_last;

  // Credit uses registered counts only; a pop this cycle is not counted.
  assign credit_ok = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < {1'b0, DepthCnt};
  assign issue     = (state_q == StRun) && (issue_cnt_q < BlockSz) && credit_ok;
  assign push      = tag_vld_q[CONV_LATENCY-1];
  assign out_valid = (fifo_cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign head_last = (idx_mem_q[rd_ptr_q] == LastIdx);

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign rd_en     = issue;
  assign rd_addr   = issue_cnt_q[ADDR_WIDTH-1:0];
  assign conv_r    = conv_r_q;
  assign conv_g    = conv_g_q;
  assign conv_b    = conv_b_q;

  // Gate the head so an empty FIFO always presents zeros.
  assign out_y     = out_valid ? y_mem_q[rd_ptr_q]   : '0;
  assign out_cb    = out_valid ? cb_mem_q[rd_ptr_q]  : '0;
  assign out_cr    = out_valid ? cr_mem_q[rd_ptr_q]  : '0;
  assign out_index = out_valid ? idx_mem_q[rd_ptr_q] : '0;
  assign out_last  = out_valid && head_last;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StRun;
          issue_cnt_d = '0;
        end
      end
      StRun: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LastIss) state_d = StDrain;
        end
      end
      StDrain: begin
        if ((inflight_q == '0) && pop && out_last) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pend_vld_d   = issue;
    pend_idx_d   = issue_cnt_q[ADDR_WIDTH-1:0];
    conv_r_d     = pend_vld_q ? rd_r : '0;
    conv_g_d     = pend_vld_q ? rd_g : '0;
    conv_b_d     = pend_vld_q ? rd_b : '0;
    tag_vld_d    = tag_vld_q;
    tag_idx_d    = tag_idx_q;
    tag_vld_d[0] = pend_vld_q;
    tag_idx_d[0] = pend_idx_q;
    for (int unsigned i = 1; i < CONV_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end

    inflight_d = inflight_q;
    if (issue && !push)      inflight_d = inflight_q + 1'b1;
    else if (!issue && push) inflight_d = inflight_q - 1'b1;

    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q;
    if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      pend_vld_q  <= 1'b0;
      pend_idx_q  <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      conv_r_q    <= '0;
      conv_g_q    <= '0;
      conv_b_q    <= '0;
      inflight_q  <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_idx_q  <= pend_idx_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      conv_r_q    <= conv_r_d;
      conv_g_q    <= conv_g_d;
      conv_b_q    <= conv_b_d;
      inflight_q  <= inflight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      y_mem_q[wr_ptr_q]   <= conv_y;
      cb_mem_q[wr_ptr_q]  <= conv_cb;
      cr_mem_q[wr_ptr_q]  <= conv_cr;
      idx_mem_q[wr_ptr_q] <= tag_idx_q[CONV_LATENCY-1];
    end
  end

`ifndef SYNTHESIS
  // The datapath cannot stall, so a push into a full FIFO means lost data.
  always @(posedge clk) begin
    if (!rst_n) begin
      assert (!(push && !pop && (fifo_cnt_q == DepthCnt)))
        else $error("ycbcr_block_sequencer: result FIFO overflow");
    end
  end
`endif

endmodule

// File: tb/tb_ycbcr_block_sequencer.sv
// Bench for ycbcr_block_sequencer. The pixel buffer holds r=i, g=i+1,
// b=255-i; the datapath stub passes r/g/b through as y/cb/cr. The stub has
// two registers behind conv_*, so together with the DUT's conv_* register
// the path from buffer data to conv_y is three cycles.
module tb_ycbcr_block_sequencer;

  localparam int IW  = 8;
  localparam int FPL = 32;
  localparam int BS  = 64;
  localparam int AW  = 6;
  localparam int DEP = 8;

  typedef logic [AW+3*FPL:0] res_t;  // {index, y, cb, cr, last}

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic           busy, done, rd_en, out_valid, out_last;
  logic           out_ready = 1'b0;
  logic [AW-1:0]  rd_addr, out_index;
  logic [IW-1:0]  rd_r = '0, rd_g = '0, rd_b = '0;
  logic [IW-1:0]  conv_r, conv_g, conv_b;
  logic [FPL-1:0] conv_y, conv_cb, conv_cr, out_y, out_cb, out_cr;
  logic [FPL-1:0] s1_y = '0, s1_cb = '0, s1_cr = '0, s2_y = '0, s2_cb = '0, s2_cr = '0;

  int checks = 0;
  int failures = 0;

  ycbcr_block_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_r      (rd_r),
    .rd_g      (rd_g),
    .rd_b      (rd_b),
    .conv_r    (conv_r),
    .conv_g    (conv_g),
    .conv_b    (conv_b),
    .conv_y    (conv_y),
    .conv_cb   (conv_cb),
    .conv_cr   (conv_cr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_cb    (out_cb),
    .out_cr    (out_cr),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_r <= 8'(rd_addr);
      rd_g <= 8'(rd_addr) + 8'd1;
      rd_b <= 8'd255 - 8'(rd_addr);
    end
    s1_y  <= 32'(conv_r);
    s1_cb <= 32'(conv_g);
    s1_cr <= 32'(conv_b);
    s2_y  <= s1_y;
    s2_cb <= s1_cb;
    s2_cr <= s1_cr;
  end
  assign conv_y  = s2_y;
  assign conv_cb = s2_cb;
  assign conv_cr = s2_cr;

  // Reference: the k-th result of a block, straight from the buffer contents.
  function automatic res_t model(input int k);
    logic [7:0] r, g, b;
    r = 8'(k);
    g = 8'(k + 1);
    b = 8'(255 - k);
    return {AW'(k), FPL'(r), FPL'(g), FPL'(b), (k == BS - 1)};
  endfunction

  // Observation log, sampled mid-cycle.
  res_t obs_q[$];
  int   obs_cyc[$];
  int   done_cyc[$];
  int   ncyc = 0, rd_cnt = 0, start_cyc = -1, first_valid_cyc = -1;

  always @(negedge clk) begin
    ncyc++;
    if (start && !busy) start_cyc = ncyc;
    if (rd_en) rd_cnt++;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = ncyc;
    if (out_valid && out_ready) begin
      obs_q.push_back({out_index, out_y, out_cb, out_cr, out_last});
      obs_cyc.push_back(ncyc);
    end
    if (done) done_cyc.push_back(ncyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
    done_cyc.delete();
    rd_cnt = 0;
    start_cyc = -1;
    first_valid_cyc = -1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // mode 0: ready held high, 1: toggling, 2: random
  task automatic run_until_done(input int mode, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(0, 99) < 40);
      endcase
      if (done_cyc.size() != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, rd_en, rd_addr, conv_r, conv_g, conv_b, out_valid, out_y, out_cb, out_cr,
         out_index, out_last} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b out_valid=%b required all 0",
               busy, done, rd_en, out_valid);
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, rd_en, out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset: busy/rd_en/out_valid=%b required 000",
               {busy, rd_en, out_valid});
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_obs();
    out_ready = 1'b1;
    pulse_start();
    run_until_done(0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_done_seen: got 0 required 1"); end
    checks++;
    if (first_valid_cyc - start_cyc != 6) begin
      failures++;
      $display("FAIL basic_latency: got %0d required 6", first_valid_cyc - start_cyc);
    end
    checks++;
    if (obs_q.size() != BS) begin
      failures++;
      $display("FAIL basic_count: got %0d required %0d", obs_q.size(), BS);
    end
    for (int k = 0; k < obs_q.size() && k < BS; k++) begin
      checks++;
      if (obs_q[k] !== model(k)) begin
        failures++;
        $display("FAIL basic_result[%0d]: got %h required %h", k, obs_q[k], model(k));
      end
    end
    if (obs_q.size() == BS) begin
      checks++;
      if (obs_cyc[BS-1] - obs_cyc[0] != BS - 1) begin
        failures++;
        $display("FAIL basic_throughput: got span %0d required %0d",
                 obs_cyc[BS-1] - obs_cyc[0], BS - 1);
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != obs_cyc[BS-1] + 1) begin
        failures++;
        $display("FAIL basic_done_timing: got %0d pulses first at %0d required 1 at %0d",
                 done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, obs_cyc[BS-1] + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    bit   ok;
    res_t held;
    clear_obs();
    out_ready = 1'b0;
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (rd_cnt > DEP || rd_cnt == 0) begin
      failures++;
      $display("FAIL bp_issue_count: got %0d required 1..%0d", rd_cnt, DEP);
    end
    held = {out_index, out_y, out_cb, out_cr, out_last};
    checks++;
    if (!out_valid || held !== model(0)) begin
      failures++;
      $display("FAIL bp_head: valid=%b got %h required %h", out_valid, held, model(0));
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({out_index, out_y, out_cb, out_cr, out_last} !== held || !out_valid) begin
      failures++;
      $display("FAIL bp_hold: got %h required %h", {out_index, out_y, out_cb, out_cr, out_last},
               held);
    end
    run_until_done(0, ok);
    checks++;
    if (!ok || obs_q.size() != BS) begin
      failures++;
      $display("FAIL bp_count: got %0d results done=%0d required %0d", obs_q.size(), ok, BS);
    end
    for (int k = 0; k < obs_q.size() && k < BS; k++) begin
      checks++;
      if (obs_q[k] !== model(k)) begin
        failures++;
        $display("FAIL bp_result[%0d]: got %h required %h", k, obs_q[k], model(k));
      end
    end
  endtask

  task automatic test_ready_pattern(input int mode, input string name);
    bit ok;
    clear_obs();
    out_ready = 1'b1;
    repeat ($urandom_range(0, 4)) @(posedge clk);
    pulse_start();
    run_until_done(mode, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || obs_q.size() != BS || done_cyc.size() != 1) begin
      failures++;
      $display("FAIL %s_count: got %0d results %0d done required %0d and 1", name,
               obs_q.size(), done_cyc.size(), BS);
    end
    for (int k = 0; k < obs_q.size() && k < BS; k++) begin
      checks++;
      if (obs_q[k] !== model(k)) begin
        failures++;
        $display("FAIL %s_result[%0d]: got %h required %h", name, k, obs_q[k], model(k));
      end
    end
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    bit ok;
    clear_obs();
    out_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (rd_en && rd_addr == AW'(30)) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mid_reset_reach30: got 0 required 1"); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    checks++;
    if ({busy, done, rd_en, rd_addr, conv_r, conv_g, conv_b, out_valid, out_y, out_cb, out_cr,
         out_index, out_last} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: busy=%b rd_en=%b out_valid=%b conv_r=%0d required 0",
               busy, rd_en, out_valid, conv_r);
    end
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (done_cyc.size() != 0 || busy) begin
      failures++;
      $display("FAIL mid_reset_no_done: got %0d done busy=%b required 0", done_cyc.size(), busy);
    end
    clear_obs();
    pulse_start();
    run_until_done(0, ok);
    checks++;
    if (!ok || obs_q.size() != BS) begin
      failures++;
      $display("FAIL mid_reset_restart_count: got %0d required %0d", obs_q.size(), BS);
    end
    for (int k = 0; k < obs_q.size() && k < BS; k++) begin
      checks++;
      if (obs_q[k] !== model(k)) begin
        failures++;
        $display("FAIL mid_reset_result[%0d]: got %h required %h", k, obs_q[k], model(k));
      end
    end
  endtask

  task automatic test_start_ignored();
    bit seen = 1'b0;
    int rd_before;
    clear_obs();
    out_ready = 1'b1;
    pulse_start();
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (!seen || busy) begin
      failures++;
      $display("FAIL done_start_ignored: done seen=%b busy=%b required 1 and 0", seen, busy);
    end
    rd_before = rd_cnt;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (rd_cnt != rd_before || rd_cnt != BS || busy) begin
      failures++;
      $display("FAIL start_ignored_reads: got %0d reads busy=%b required %0d", rd_cnt, busy, BS);
    end
    checks++;
    if (obs_q.size() != BS || done_cyc.size() != 1) begin
      failures++;
      $display("FAIL start_ignored_block: got %0d results %0d done required %0d and 1",
               obs_q.size(), done_cyc.size(), BS);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ready_pattern(1, "toggle");
    test_ready_pattern(2, "random_a");
    test_ready_pattern(2, "random_b");
    test_mid_reset();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
